// File: rtl/vector_exec_pipe.sv
// ----------------------------------------------------------------------------
// vector_exec_pipe
//
// Pipelined vector/scalar execution unit. A LANES x LW-bit operand pair is split
// into independent lanes. Each lane computes add/sub/mul/shift/logic, with
// optional signed saturation on add/sub. Compute is combinational ahead of
// stage 1. Stages 2..STAGES only delay the result, zero flag and tag. Every
// stage carries its own valid bit, and a valid/ready handshake lets the core
// stall or flush the pipe without losing or duplicating results.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   vec_op                1 = all lanes, 0 = scalar (lane 0 only)
//   sel, sat              operation code, saturate signed add/sub
//   a, b                  operands, lane i = bits [i*LW +: LW]
//   rd_in                 destination tag carried with the operation
//   flush                 discard every in-flight operation
//   out_valid / out_ready output handshake
//   result, flag_z        lane results, zero flag over the active lanes
//   rd_out                tag belonging to result
//   occupancy             number of valid stages (registered)
// ----------------------------------------------------------------------------
module vector_exec_pipe #(
    parameter int LANES  = 6,
    parameter int LW     = 32,
    parameter int STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                vec_op,
    input  logic [2:0]          sel,
    input  logic                sat,
    input  logic [LANES*LW-1:0] a,
    input  logic [LANES*LW-1:0] b,
    input  logic [3:0]          rd_in,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*LW-1:0] result,
    output logic                flag_z,
    output logic [3:0]          rd_out,
    output logic [2:0]          occupancy
);

    localparam int W = LANES * LW;

    localparam logic [LW-1:0] SAT_MAX = {1'b0, {(LW-1){1'b1}}};
    localparam logic [LW-1:0] SAT_MIN = {1'b1, {(LW-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_SHL = 3'b011,
        OP_SHR = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } op_e;

    // One lane of the ALU. Add/sub are done one bit wider on sign-extended
    // operands, so a signed overflow shows up as the two top bits disagreeing.
    function automatic logic [LW-1:0] lane_op(
        input logic [LW-1:0] x,
        input logic [LW-1:0] y,
        input op_e           op,
        input logic          s
    );
        logic [LW:0]   wide;
        logic [4:0]    sh;
        logic [LW-1:0] r;
        wide = '0;
        sh   = y[4:0];
        r    = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                if (op == OP_ADD) wide = {x[LW-1], x} + {y[LW-1], y};
                else              wide = {x[LW-1], x} - {y[LW-1], y};
                r = wide[LW-1:0];
                if (s && (wide[LW] != wide[LW-1])) r = wide[LW] ? SAT_MIN : SAT_MAX;
            end
            OP_MUL:  r = x * y;
            OP_SHL:  r = (int'(sh) >= LW) ? '0 : (x << sh);
            OP_SHR:  r = (int'(sh) >= LW) ? '0 : (x >> sh);
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            default: r = '0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Combinational compute feeding stage 1
    // ------------------------------------------------------------------
    logic [W-1:0] res_c;
    logic         z_c;

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        res_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (vec_op || (i == 0))
                res_c[i*LW +: LW] = lane_op(a[i*LW +: LW], b[i*LW +: LW], op_e'(sel), sat);
        end
        // Inactive lanes are already forced to zero, so a whole-word compare
        // only looks at the active lanes.
        z_c = (res_c == '0);
    end

    // ------------------------------------------------------------------
    // Valid/ready chain
    // ------------------------------------------------------------------
    logic [STAGES:1] v_q;
    logic [STAGES:1] v_d;
    logic [STAGES:1] rdy;
    logic [STAGES:0] v_chain;
    logic [2:0]      occ_d;
    logic            accept;

    logic [W-1:0] res_q [1:STAGES];
    logic [3:0]   rd_q  [1:STAGES];
    logic [STAGES:1] z_q;

    // A stage can load when it is empty or its content leaves this cycle.
    // Walking from the output backwards lets bubbles collapse.
    always_comb begin
        rdy[STAGES] = !v_q[STAGES] || out_ready;
        for (int k = STAGES - 1; k >= 1; k--)
            rdy[k] = !v_q[k] || rdy[k+1];
    end

    assign in_ready = rdy[1] && !flush && !rst;
    assign accept   = in_valid && in_ready;

    // Bit 0 is the valid bit entering stage 1, bit k the valid of stage k.
    assign v_chain = {v_q, accept};

    always_comb begin
        v_d   = '0;
        occ_d = '0;
        for (int k = 1; k <= STAGES; k++) begin
            if (!flush)
                v_d[k] = rdy[k] ? v_chain[k-1] : v_q[k];
            occ_d = occ_d + {2'b00, v_d[k]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so each stage
    // samples the value its neighbour held before the edge.
    // NOTE: the data registers are reset as well as the valid bits, because the
    // last stage drives result/flag_z/rd_out, which must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q       <= '0;
            z_q       <= '0;
            occupancy <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                res_q[k] <= '0;
                rd_q[k]  <= '0;
            end
        end else begin
            v_q       <= v_d;
            occupancy <= occ_d;
            if (accept) begin
                res_q[1] <= res_c;
                z_q[1]   <= z_c;
                rd_q[1]  <= rd_in;
            end
            // Data only moves along with a valid operation, so a stalled output
            // stage holds still and empty stages keep their previous contents.
            for (int k = 2; k <= STAGES; k++) begin
                if (!flush && rdy[k] && v_q[k-1]) begin
                    res_q[k] <= res_q[k-1];
                    z_q[k]   <= z_q[k-1];
                    rd_q[k]  <= rd_q[k-1];
                end
            end
        end
    end

    assign out_valid = v_q[STAGES];
    assign result    = res_q[STAGES];
    assign flag_z    = z_q[STAGES];
    assign rd_out    = rd_q[STAGES];

endmodule

// File: tb/tb_vector_exec_pipe.sv
// ----------------------------------------------------------------------------
// tb_vector_exec_pipe
//
// Directed, self-checking bench for vector_exec_pipe with the default
// configuration (6 lanes of 32 bits, 2 stages). Inputs are driven 1 time unit
// after a rising edge, and outputs are sampled between edges.
// ----------------------------------------------------------------------------
module tb_vector_exec_pipe;

    localparam int LANES  = 6;
    localparam int LW     = 32;
    localparam int STAGES = 2;
    localparam int W      = LANES * LW;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic          vec_op    = 1'b0;
    logic [2:0]    sel       = 3'b000;
    logic          sat       = 1'b0;
    logic [W-1:0]  a         = '0;
    logic [W-1:0]  b         = '0;
    logic [3:0]    rd_in     = 4'h0;
    logic          flush     = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          flag_z;
    logic [3:0]    rd_out;
    logic [2:0]    occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]    s;
        logic          st;
        logic [LW-1:0] x;
        logic [LW-1:0] y;
        logic [LW-1:0] e;
    } vec_t;

    vector_exec_pipe #(.LANES(LANES), .LW(LW), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vec_op    (vec_op),
        .sel       (sel),
        .sat       (sat),
        .a         (a),
        .b         (b),
        .rd_in     (rd_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .rd_out    (rd_out),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, limit 200000", $time);
        $fatal(1);
    end

    function automatic logic [W-1:0] splat(input logic [LW-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*LW +: LW] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] s, input logic st, input logic vo,
                         input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] rd);
        sel = s; sat = st; vec_op = vo; a = x; b = y; rd_in = rd; in_valid = 1'b1;
    endtask

    // Runs one operation through an empty pipe and captures the first result.
    task automatic run_op(input logic [2:0] s, input logic st, input logic vo,
                          input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] rd,
                          output logic [W-1:0] res, output logic z, output logic [3:0] rdo,
                          output int lat);
        out_ready = 1'b1;
        issue(s, st, vo, x, y, rd);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 16) begin
            tick();
            lat++;
        end
        res = result; z = flag_z; rdo = rd_out;
        tick();
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (result !== '0)      begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
        n_cmp++; if (flag_z !== 1'b0)    begin n_bad++; $display("FAIL reset_flag_z: got %b want 0", flag_z); end
        n_cmp++; if (rd_out !== 4'h0)    begin n_bad++; $display("FAIL reset_rd_out: got %h want 0", rd_out); end
        n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_vec_add();
        logic [W-1:0] x, y, exp, res;
        logic z;
        logic [3:0] rdo;
        int lat;
        for (int i = 0; i < LANES; i++) begin
            x[i*LW +: LW]   = LW'(i);
            y[i*LW +: LW]   = 32'd10;
            exp[i*LW +: LW] = LW'(10 + i);
        end
        run_op(3'b000, 1'b0, 1'b1, x, y, 4'hA, res, z, rdo, lat);
        n_cmp++; if (lat != STAGES)  begin n_bad++; $display("FAIL vec_add_latency: got %0d want %0d", lat, STAGES); end
        n_cmp++; if (res !== exp)    begin n_bad++; $display("FAIL vec_add_result: got %h want %h", res, exp); end
        n_cmp++; if (z !== 1'b0)     begin n_bad++; $display("FAIL vec_add_flag_z: got %b want 0", z); end
        n_cmp++; if (rdo !== 4'hA)   begin n_bad++; $display("FAIL vec_add_rd_out: got %h want a", rdo); end
    endtask

    task automatic test_saturation();
        vec_t t [0:4];
        logic [W-1:0] res;
        logic z;
        logic [3:0] rdo;
        int lat;
        t[0] = '{3'b000, 1'b1, 32'h7FFF_FFF0, 32'h0000_0020, 32'h7FFF_FFFF};
        t[1] = '{3'b000, 1'b0, 32'h7FFF_FFF0, 32'h0000_0020, 32'h8000_0010};
        t[2] = '{3'b001, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000};
        t[3] = '{3'b001, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        t[4] = '{3'b000, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        for (int i = 0; i < 5; i++) begin
            run_op(t[i].s, t[i].st, 1'b1, splat(t[i].x), splat(t[i].y), 4'(i), res, z, rdo, lat);
            n_cmp++;
            if (res !== splat(t[i].e)) begin
                n_bad++;
                $display("FAIL sat_case%0d: got %h want %h", i, res, splat(t[i].e));
            end
        end
    endtask

    task automatic test_scalar();
        logic [W-1:0] res, x, exp;
        logic z;
        logic [3:0] rdo;
        int lat;
        run_op(3'b001, 1'b0, 1'b0, splat(32'd5), splat(32'd5), 4'h3, res, z, rdo, lat);
        n_cmp++; if (res !== '0)   begin n_bad++; $display("FAIL scalar_sub_result: got %h want 0", res); end
        n_cmp++; if (z !== 1'b1)   begin n_bad++; $display("FAIL scalar_sub_flag_z: got %b want 1", z); end
        x = splat(32'd5);
        x[3*LW +: LW] = 32'd7;
        exp = '0;
        exp[3*LW +: LW] = 32'd2;
        run_op(3'b001, 1'b0, 1'b1, x, splat(32'd5), 4'h4, res, z, rdo, lat);
        n_cmp++; if (res !== exp)  begin n_bad++; $display("FAIL vector_sub_result: got %h want %h", res, exp); end
        n_cmp++; if (z !== 1'b0)   begin n_bad++; $display("FAIL vector_sub_flag_z: got %b want 0", z); end
        // Scalar mode with a nonzero lane 0: upper lanes still forced to zero.
        exp = '0;
        exp[LW-1:0] = 32'd7;
        run_op(3'b000, 1'b0, 1'b0, splat(32'd3), splat(32'd4), 4'h5, res, z, rdo, lat);
        n_cmp++; if (res !== exp)  begin n_bad++; $display("FAIL scalar_add_result: got %h want %h", res, exp); end
        n_cmp++; if (z !== 1'b0)   begin n_bad++; $display("FAIL scalar_add_flag_z: got %b want 0", z); end
    endtask

    task automatic test_lane_ops();
        vec_t t [0:8];
        logic [W-1:0] res;
        logic z;
        logic [3:0] rdo;
        int lat;
        t[0] = '{3'b010, 1'b0, 32'h1234_5678, 32'h0000_00FF, 32'h2222_2188};
        t[1] = '{3'b011, 1'b0, 32'h1234_5678, 32'h0000_0004, 32'h2345_6780};
        t[2] = '{3'b100, 1'b0, 32'h1234_5678, 32'h0000_0004, 32'h0123_4567};
        t[3] = '{3'b101, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608};
        t[4] = '{3'b110, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1F3F_5F7F};
        t[5] = '{3'b111, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1D3B_5977};
        t[6] = '{3'b010, 1'b1, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
        t[7] = '{3'b011, 1'b0, 32'hFF00_0000, 32'h0000_0028, 32'h0000_0000};
        t[8] = '{3'b100, 1'b0, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
        for (int i = 0; i < 9; i++) begin
            run_op(t[i].s, t[i].st, 1'b1, splat(t[i].x), splat(t[i].y), 4'(i), res, z, rdo, lat);
            n_cmp++;
            if (res !== splat(t[i].e)) begin
                n_bad++;
                $display("FAIL op_case%0d_result: got %h want %h", i, res, splat(t[i].e));
            end
            n_cmp++;
            if (z !== (t[i].e == '0)) begin
                n_bad++;
                $display("FAIL op_case%0d_flag_z: got %b want %b", i, z, (t[i].e == '0));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]   got_rd  [$];
        logic [W-1:0] got_res [$];
        int  idx;
        logic acc;
        out_ready = 1'b0;
        issue(3'b000, 1'b0, 1'b1, splat(32'd0), splat(32'd100), 4'd0);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept0: got %b want 1", in_ready); end
        tick();
        issue(3'b000, 1'b0, 1'b1, splat(32'd1), splat(32'd100), 4'd1);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept1: got %b want 1", in_ready); end
        tick();
        issue(3'b000, 1'b0, 1'b1, splat(32'd2), splat(32'd100), 4'd2);
        #1;
        n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL bp_full_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (occupancy !== 3'd2) begin n_bad++; $display("FAIL bp_full_occupancy: got %0d want 2", occupancy); end
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || rd_out !== 4'd0 || result !== splat(32'd100)) begin
                n_bad++;
                $display("FAIL bp_hold_cycle%0d: got v=%b rd=%h res=%h want v=1 rd=0 res=%h",
                         c, out_valid, rd_out, result, splat(32'd100));
            end
            tick();
        end
        out_ready = 1'b1;
        idx = 2;
        for (int c = 0; c < 30 && (got_rd.size() < 5 || idx < 5); c++) begin
            if (idx < 5) issue(3'b000, 1'b0, 1'b1, splat(LW'(idx)), splat(32'd100), 4'(idx));
            else         in_valid = 1'b0;
            #1;
            acc = in_valid && in_ready;
            if (out_valid === 1'b1) begin
                got_rd.push_back(rd_out);
                got_res.push_back(result);
            end
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        n_cmp++; if (got_rd.size() != 5) begin n_bad++; $display("FAIL bp_count: got %0d want 5", got_rd.size()); end
        for (int k = 0; k < got_rd.size() && k < 5; k++) begin
            n_cmp++;
            if (got_rd[k] !== 4'(k) || got_res[k] !== splat(LW'(100 + k))) begin
                n_bad++;
                $display("FAIL bp_order%0d: got rd=%h res=%h want rd=%h res=%h",
                         k, got_rd[k], got_res[k], 4'(k), splat(LW'(100 + k)));
            end
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        int lat;
        out_ready = 1'b0;
        issue(3'b000, 1'b0, 1'b1, splat(32'd1), splat(32'd100), 4'd1);
        tick();
        issue(3'b000, 1'b0, 1'b1, splat(32'd2), splat(32'd100), 4'd2);
        tick();
        // Full pipe with a ready consumer: consume and accept on the same edge.
        out_ready = 1'b1;
        issue(3'b000, 1'b0, 1'b1, splat(32'd3), splat(32'd100), 4'd3);
        #1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL full_flow_in_ready: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (occupancy !== 3'd2) begin n_bad++; $display("FAIL full_flow_occupancy: got %0d want 2", occupancy); end
        n_cmp++; if (rd_out !== 4'd2)    begin n_bad++; $display("FAIL full_flow_rd_out: got %h want 2", rd_out); end
        flush = 1'b1;
        issue(3'b000, 1'b0, 1'b1, splat(32'd8), splat(32'd100), 4'd8);
        #1;
        n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL flush_occupancy: got %0d want 0", occupancy); end
        issue(3'b000, 1'b0, 1'b1, splat(32'd9), splat(32'd100), 4'd9);
        #1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL post_flush_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 16) begin
            tick();
            lat++;
        end
        n_cmp++; if (lat != STAGES)      begin n_bad++; $display("FAIL post_flush_latency: got %0d want %0d", lat, STAGES); end
        n_cmp++; if (rd_out !== 4'd9 || result !== splat(32'd109)) begin
            n_bad++;
            $display("FAIL post_flush_result: got rd=%h res=%h want rd=9 res=%h", rd_out, result, splat(32'd109));
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_flush_single: got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] res;
        logic z;
        logic [3:0] rdo;
        int lat;
        out_ready = 1'b0;
        issue(3'b000, 1'b0, 1'b1, splat(32'd5), splat(32'd1), 4'd5);
        tick();
        issue(3'b000, 1'b0, 1'b1, splat(32'd6), splat(32'd1), 4'd6);
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL arst_occupancy: got %0d want 0", occupancy); end
        n_cmp++; if (result !== '0 || rd_out !== 4'h0) begin
            n_bad++; $display("FAIL arst_outputs: got res=%h rd=%h want 0", result, rd_out);
        end
        n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL arst_in_ready: got %b want 0", in_ready); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL arst_release_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (result !== '0 || flag_z !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL arst_release_outputs: got v=%b res=%h z=%b want all 0", out_valid, result, flag_z);
        end
        out_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_no_partial: got %b want 0", out_valid); end
        run_op(3'b000, 1'b0, 1'b1, splat(32'd2), splat(32'd3), 4'd7, res, z, rdo, lat);
        n_cmp++; if (res !== splat(32'd5) || rdo !== 4'd7) begin
            n_bad++; $display("FAIL arst_recover: got res=%h rd=%h want res=%h rd=7", res, rdo, splat(32'd5));
        end
    endtask

    initial begin
        test_reset();
        test_vec_add();
        test_saturation();
        test_scalar();
        test_lane_ops();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
